// File: rtl/load_store_unit.sv
// Load/store unit: the pipeline's initiator into a word-wide asynchronous data memory.
// Optional macro LSU_BOUNDS_CHECK_EN rejects word indices >= MEM_WORDS like a misalignment.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        memReadFlag,
  output logic        memWriteFlag,
  input  logic [31:0] memRdata
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} lsuState_e;

  lsuState_e   stateQ, stateD;
  logic [31:0] addrQ, wdataQ, holdQ;
  logic [1:0]  sizeQ;
  logic        signedQ, writeQ, errQ;
  logic        accept, reqErr;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] mergeData;

  assign accept = req_valid && req_ready;

  always_comb begin
    reqErr = (req_size == 2'd3) ||
             (req_size == 2'd1 && req_addr[0]) ||
             (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS) reqErr = 1'b1;
`endif
  end

  // State register plus captured request and read-hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= StIdle;
      addrQ   <= '0;
      wdataQ  <= '0;
      holdQ   <= '0;
      sizeQ   <= '0;
      signedQ <= 1'b0;
      writeQ  <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
        sizeQ   <= req_size;
        signedQ <= req_signed;
        writeQ  <= req_write;
        errQ    <= reqErr;
      end
      if (stateQ == StRead) holdQ <= memRdata;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle: begin
        if (accept) begin
          if (reqErr)                        stateD = StResp;
          else if (req_write && req_size == 2'd2) stateD = StWrite;
          else                               stateD = StRead;
        end
      end
      StRead:  stateD = writeQ ? StWrite : StResp;
      StWrite: stateD = StResp;
      default: stateD = StIdle;
    endcase
  end

  // Lane extraction and sub-word merge over the held word (little-endian lanes)
  always_comb begin
    mergeData = holdQ;
    case (addrQ[1:0])
      2'd0:    byteSel = holdQ[7:0];
      2'd1:    byteSel = holdQ[15:8];
      2'd2:    byteSel = holdQ[23:16];
      default: byteSel = holdQ[31:24];
    endcase
    halfSel = addrQ[1] ? holdQ[31:16] : holdQ[15:0];
    if (sizeQ == 2'd0) begin
      case (addrQ[1:0])
        2'd0:    mergeData[7:0]   = wdataQ[7:0];
        2'd1:    mergeData[15:8]  = wdataQ[7:0];
        2'd2:    mergeData[23:16] = wdataQ[7:0];
        default: mergeData[31:24] = wdataQ[7:0];
      endcase
    end else if (addrQ[1]) begin
      mergeData[31:16] = wdataQ[15:0];
    end else begin
      mergeData[15:0] = wdataQ[15:0];
    end
  end

  always_comb begin
    req_ready    = (stateQ == StIdle);
    resp_valid   = (stateQ == StResp);
    resp_err     = (stateQ == StResp) && errQ;
    resp_rdata   = '0;
    memReadFlag  = (stateQ == StRead);
    memWriteFlag = (stateQ == StWrite);
    memAddr      = '0;
    memData      = '0;
    if (stateQ == StRead || stateQ == StWrite) memAddr = {2'b00, addrQ[31:2]};
    if (stateQ == StWrite) memData = (sizeQ == 2'd2) ? wdataQ : mergeData;
    if (stateQ == StResp && !errQ && !writeQ) begin
      case (sizeQ)
        2'd0:    resp_rdata = {{24{signedQ & byteSel[7]}}, byteSel};
        2'd1:    resp_rdata = {{16{signedQ & halfSel[15]}}, halfSel};
        default: resp_rdata = holdQ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word asynchronous memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] memAddr, memData, memRdata;
  logic        memReadFlag, memWriteFlag;

  logic [31:0] mem [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .memAddr(memAddr), .memData(memData), .memReadFlag(memReadFlag),
    .memWriteFlag(memWriteFlag), .memRdata(memRdata)
  );

  assign memRdata = mem[memAddr[4:0]];
  always @(posedge clk) if (memWriteFlag) mem[memAddr[4:0]] <= memData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch until resp_valid (bounded) and one cycle beyond.
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output logic sawRd, output logic sawWr, output logic [31:0] wrAddr,
                       output logic [31:0] wrData, output logic respAfter);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rdata = '0; err = 1'b0; sawRd = 1'b0; sawWr = 1'b0;
    wrAddr = '0; wrData = '0; respAfter = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (memReadFlag) sawRd = 1'b1;
      if (memWriteFlag) begin sawWr = 1'b1; wrAddr = memAddr; wrData = memData; end
      if (resp_valid) begin rdata = resp_rdata; err = resp_err; break; end
    end
    if (!resp_valid) lat = 99;
    @(negedge clk);
    respAfter = resp_valid;
  endtask

  int          lat;
  logic [31:0] rd, wa, wdv;
  logic        er, sr, sw, ra;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_resp_err", {31'b0, resp_err}, 32'd0);
    chk("reset_memAddr", memAddr, 32'd0);
    chk("reset_memData", memData, 32'd0);
    chk("reset_strobes", {30'b0, memReadFlag, memWriteFlag}, 32'd0);

    // Word store then word load
    doReq(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("sw_latency", lat, 32'd2);
    chk("sw_wrote", {30'b0, sr, sw}, 32'd1);
    chk("sw_memAddr", wa, 32'd2);
    chk("sw_memData", wdv, 32'hDEADBEEF);
    doReq(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lw_latency", lat, 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, er}, 32'd0);
    chk("lw_resp_one_cycle", {31'b0, ra}, 32'd0);
    chk("lw_strobes", {30'b0, sr, sw}, 32'd2);

    // Sub-word store uses read-modify-write
    doReq(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, lat, rd, er, sr, sw, wa, wdv, ra);
    doReq(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AA, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("sb_latency", lat, 32'd3);
    chk("sb_strobes", {30'b0, sr, sw}, 32'd3);
    chk("sb_memData", wdv, 32'h1122AA44);
    doReq(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000BEEF, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("sh_memData", wdv, 32'hBEEFAA44);

    // Extraction and extension
    doReq(1'b1, 2'd2, 1'b0, 32'h8, 32'h80FF7F01, lat, rd, er, sr, sw, wa, wdv, ra);
    doReq(1'b0, 2'd0, 1'b1, 32'hA, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lb_0xA", rd, 32'hFFFFFFFF);
    doReq(1'b0, 2'd0, 1'b0, 32'hA, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lbu_0xA", rd, 32'h000000FF);
    doReq(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lh_0xA", rd, 32'hFFFF80FF);
    doReq(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lhu_0x8", rd, 32'h00007F01);
    doReq(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lb_0x8", rd, 32'h00000001);
    doReq(1'b1, 2'd2, 1'b0, 32'h8, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("sw_resp_rdata_zero", rd, 32'h0);
    doReq(1'b1, 2'd2, 1'b0, 32'h8, 32'h80FF7F01, lat, rd, er, sr, sw, wa, wdv, ra);

    // Misaligned and illegal-size requests
    doReq(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lw_0x6_latency", lat, 32'd1);
    chk("lw_0x6_err", {31'b0, er}, 32'd1);
    chk("lw_0x6_strobes", {30'b0, sr, sw}, 32'd0);
    doReq(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("lh_0x5_latency", lat, 32'd1);
    chk("lh_0x5_err", {31'b0, er}, 32'd1);
    chk("lh_0x5_strobes", {30'b0, sr, sw}, 32'd0);
    doReq(1'b1, 2'd3, 1'b0, 32'h8, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("size3_err", {31'b0, er}, 32'd1);
    chk("size3_strobes", {30'b0, sr, sw}, 32'd0);

    // Reset during the READ phase of a sub-word store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'hA; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_in_read", {30'b0, memReadFlag, memWriteFlag}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_strobes", {30'b0, memReadFlag, memWriteFlag}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("rst_mid_no_resp2", {31'b0, resp_valid}, 32'd0);
    doReq(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
    chk("rst_mid_mem_unchanged", rd, 32'h80FF7F01);

    // Out-of-range word index
    doReq(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, lat, rd, er, sr, sw, wa, wdv, ra);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("bounds_err", {31'b0, er}, 32'd1);
    chk("bounds_strobes", {30'b0, sr, sw}, 32'd0);
    chk("bounds_latency", lat, 32'd1);
`else
    chk("nobounds_err", {31'b0, er}, 32'd0);
    chk("nobounds_strobes", {30'b0, sr, sw}, 32'd2);
    chk("nobounds_latency", lat, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
